id_hazard_scoreboard: RTL and testbench
=======================================

// Module: id_hazard_scoreboard
// PURPOSE
//  Issue-side controller for the ID/EXE pipeline register. It tracks in-flight register writes
//  and decides, each cycle, whether the decoded ID instruction is issued into ID/EXE or replaced
//  by a bubble. Drives that register's flush and the IF/ID freeze; writeback retires entries.
// PARAMETERS
//  NUM_REGS  16  architectural registers tracked (R0..R15)
//  REG_W     4   register index width, clog2(NUM_REGS)
//  CNT_W     2   per-register pending-write counter width; max in-flight writes = 2**CNT_W-1
// PORTS
//  clk           in   1        rising-edge clock
//  reset_n       in   1        reset, asynchronous, active-low
//  id_valid      in   1        ID holds a decoded instruction
//  id_src1       in   REG_W    Rn index
//  id_use_src1   in   1        instruction reads Rn
//  id_src2       in   REG_W    Rm index (Rd for stores)
//  id_use_src2   in   1        instruction reads src2 (!imm or MEM_W_EN)
//  id_wb_en      in   1        instruction writes a register
//  id_dest       in   REG_W    destination index
//  br_taken      in   1        branch resolved taken in EXE this cycle
//  wb_valid      in   1        writeback retiring a register write this cycle
//  wb_dest       in   REG_W    retiring destination
//  issue         out  1        ID instruction enters ID/EXE at next edge (comb)
//  freeze        out  1        hold PC and IF/ID this cycle (comb)
//  id_exe_flush  out  1        load bubble into ID/EXE at next edge (comb)
//  pending_mask  out  NUM_REGS bit i = counter[i]!=0 (registered)
//  sb_err        out  1        sticky: retire of a non-pending register
//  stall_cycles  out  32       freeze-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n=0, async): all counters 0, pending_mask=0, sb_err=0, stall_cycles=0.
//    Combinational outputs follow their equations (issue=0 unless id_valid).
//  - src_busy(s) = cnt[s]!=0 && !(wb_valid && wb_dest==s && cnt[s]==1).
//    Same-cycle WB bypasses: the register file writes on the opposite clock edge.
//  - dest_full = id_wb_en && cnt[id_dest]==2**CNT_W-1 && !(wb_valid && wb_dest==id_dest).
//  - hazard = id_valid && ((id_use_src1 && src_busy(id_src1)) ||
//    (id_use_src2 && src_busy(id_src2)) || dest_full).
//  - issue = id_valid && !hazard && !br_taken.
//  - freeze = hazard && !br_taken.
//  - id_exe_flush = br_taken || hazard || !id_valid.
//  - br_taken has priority: ID is squashed (no issue, no freeze, no counter increment).
//  - Counter update at posedge, for each register r:
//    inc = issue && id_wb_en && id_dest==r; dec = wb_valid && wb_dest==r.
//    inc&dec -> unchanged; inc only -> +1; dec only -> -1.
//  - Retire of a register whose counter is 0: counter stays 0 and sb_err sets.
//    sb_err is cleared only by reset.
//  - Counters never wrap. Saturation is prevented by the dest_full stall, never by dropping.
//  - pending_mask is registered from the next-state counters: visible one cycle after issue/retire.
//  - Latency: a hazard stalls exactly until the producing write reaches WB.
//    Issue happens in the same cycle as that WB.
// CONFIGURATION
//  SCOREBOARD_STATS_EN defined: stall_cycles increments by 1 each cycle freeze=1, wraps at 2**32.
//  SCOREBOARD_STATS_EN undefined: stall_cycles tied to 32'd0; no counter logic.
// TESTING
//  1. Reset mid-stall: R3 pending, freeze=1; drop reset_n -> pending_mask=0, freeze=0 immediately.
//  2. Issue ADD R3 (wb_en, dest=3) -> next cycle pending_mask=16'h0008.
//     Then SUB reading R3 -> freeze=1, id_exe_flush=1, issue=0.
//  3. Same cycle: WB wb_dest=3 with cnt[3]=1, ID reads R3 -> issue=1, freeze=0.
//     Then pending_mask[3]=0.
//  4. br_taken=1 while ID has a hazard on R5 -> issue=0, freeze=0, id_exe_flush=1;
//     cnt[5] unchanged.
//  5. Issue 3 writes to R7 with no WB (CNT_W=2), 4th writer -> freeze=1 (dest_full).
//     WB R7 in the same cycle as the 4th -> issue=1, cnt[7] stays 3.
//  6. wb_valid=1, wb_dest=9 while cnt[9]=0 -> sb_err=1 and persists; cnt[9]=0.
//     With SCOREBOARD_STATS_EN: 4 freeze cycles -> stall_cycles=4.

Source files
------------

// File: rtl/id_hazard_scoreboard.sv
// ID/EXE issue controller: tracks in-flight register writes and decides whether ID is issued or bubbled.
// Optional freeze-cycle statistics counter enabled by defining SCOREBOARD_STATS_EN.
module id_hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned REG_W    = 4,
  parameter int unsigned CNT_W    = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_src1,
  input  logic                id_use_src1,
  input  logic [REG_W-1:0]    id_src2,
  input  logic                id_use_src2,
  input  logic                id_wb_en,
  input  logic [REG_W-1:0]    id_dest,
  input  logic                br_taken,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_dest,
  output logic                issue,
  output logic                freeze,
  output logic                id_exe_flush,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                sb_err,
  output logic [31:0]         stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] pend_nxt;
  logic [NUM_REGS-1:0] inc_r;
  logic [NUM_REGS-1:0] dec_r;
  logic                src1_busy;
  logic                src2_busy;
  logic                dest_full;
  logic                hazard;
  logic                retire_err;

  // A source whose last pending write retires this cycle is readable: the
  // register file writes on the opposite clock edge.
  always_comb begin
    src1_busy = (cnt[id_src1] != '0) &&
                !(wb_valid && (wb_dest == id_src1) && (cnt[id_src1] == CNT_ONE));
    src2_busy = (cnt[id_src2] != '0) &&
                !(wb_valid && (wb_dest == id_src2) && (cnt[id_src2] == CNT_ONE));
    dest_full = id_wb_en && (cnt[id_dest] == CNT_MAX) &&
                !(wb_valid && (wb_dest == id_dest));
    hazard    = id_valid && ((id_use_src1 && src1_busy) ||
                             (id_use_src2 && src2_busy) || dest_full);
  end

  always_comb begin
    issue        = id_valid && !hazard && !br_taken;
    freeze       = hazard && !br_taken;
    id_exe_flush = br_taken || hazard || !id_valid;
  end

  always_comb begin
    retire_err = wb_valid && (cnt[wb_dest] == '0);
    inc_r      = '0;
    dec_r      = '0;
    pend_nxt   = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      inc_r[r]   = issue && id_wb_en && (id_dest == REG_W'(r));
      dec_r[r]   = wb_valid && (wb_dest == REG_W'(r));
      cnt_nxt[r] = cnt[r];
      if (inc_r[r] && !dec_r[r] && (cnt[r] != CNT_MAX))
        cnt_nxt[r] = cnt[r] + CNT_ONE;
      else if (dec_r[r] && !inc_r[r] && (cnt[r] != '0))
        cnt_nxt[r] = cnt[r] - CNT_ONE;
      pend_nxt[r] = (cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      pending_mask <= '0;
      sb_err       <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
      pending_mask <= pend_nxt;
      if (retire_err) sb_err <= 1'b1;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    stall_q <= '0;
    else if (freeze) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed table-driven bench for id_hazard_scoreboard plus reset and statistics sequences.
module tb_id_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_valid, id_use_src1, id_use_src2, id_wb_en, br_taken, wb_valid;
  logic [3:0]  id_src1, id_src2, id_dest, wb_dest;
  logic        issue, freeze, id_exe_flush, sb_err;
  logic [15:0] pending_mask;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic [3:0] s1;
    logic       u1;
    logic [3:0] s2;
    logic       u2;
    logic       we;
    logic [3:0] dst;
    logic       br;
    logic       wbv;
    logic [3:0] wbd;
    logic [2:0] cmb;   // {issue, freeze, id_exe_flush} before the edge
    logic [15:0] mask; // pending_mask after the edge
    logic       err;   // sb_err after the edge
  } vec_t;

  vec_t vecs [22];

  id_hazard_scoreboard #(.NUM_REGS(16), .REG_W(4), .CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_src1(id_src1), .id_use_src1(id_use_src1),
    .id_src2(id_src2), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
    .id_dest(id_dest), .br_taken(br_taken), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .issue(issue), .freeze(freeze), .id_exe_flush(id_exe_flush),
    .pending_mask(pending_mask), .sb_err(sb_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [3:0] s1, input logic u1,
                              input logic [3:0] s2, input logic u2, input logic we,
                              input logic [3:0] dst, input logic br, input logic wbv,
                              input logic [3:0] wbd, input logic [2:0] cmb,
                              input logic [15:0] mask, input logic err);
    vec_t t;
    t.v = v; t.s1 = s1; t.u1 = u1; t.s2 = s2; t.u2 = u2; t.we = we; t.dst = dst;
    t.br = br; t.wbv = wbv; t.wbd = wbd; t.cmb = cmb; t.mask = mask; t.err = err;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_src1 = t.s1; id_use_src1 = t.u1; id_src2 = t.s2;
    id_use_src2 = t.u2; id_wb_en = t.we; id_dest = t.dst; br_taken = t.br;
    wb_valid = t.wbv; wb_dest = t.wbd;
  endtask

  task automatic set_idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 16'h0, 0));
  endtask

  initial begin
    set_idle();
    // idle / ADD R3 / SUB stalled on R3 / SUB issued with same-cycle WB of R3
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 16'h0000, 0);
    vecs[1]  = mk(1, 1, 1, 2, 1, 1, 3, 0, 0, 0, 3'b100, 16'h0008, 0);
    vecs[2]  = mk(1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 3'b011, 16'h0008, 0);
    vecs[3]  = mk(1, 3, 1, 0, 0, 1, 4, 0, 1, 3, 3'b100, 16'h0010, 0);
    // R5 writer, then branch squashes a hazarded writer of R5: cnt[5] must stay 1
    vecs[4]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 3'b100, 16'h0030, 0);
    vecs[5]  = mk(1, 5, 1, 0, 0, 1, 5, 1, 0, 0, 3'b001, 16'h0030, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 3'b001, 16'h0010, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 3'b001, 16'h0000, 0);
    // Saturate R7: three writers, fourth stalls, fourth with WB R7 issues, drain 3
    vecs[8]  = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 3'b100, 16'h0080, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 3'b100, 16'h0080, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 3'b100, 16'h0080, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 3'b011, 16'h0080, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 1, 7, 0, 1, 7, 3'b100, 16'h0080, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 3'b001, 16'h0080, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 3'b001, 16'h0080, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 3'b001, 16'h0000, 0);
    // Retire of idle R9 sets sticky error
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 3'b001, 16'h0000, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 16'h0000, 1);
    // src2 hazard honoured only when id_use_src2
    vecs[18] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 3'b100, 16'h0004, 1);
    vecs[19] = mk(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 3'b011, 16'h0004, 1);
    vecs[20] = mk(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 3'b100, 16'h0004, 1);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3'b001, 16'h0000, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mask", 32'(pending_mask), 32'h0);
    check("rst_err", 32'(sb_err), 32'h0);
    check("rst_stall", stall_cycles, 32'h0);
    check("rst_comb", 32'({issue, freeze, id_exe_flush}), 32'b001);

    // Reset asserted mid-stall clears state immediately
    @(negedge clk);
    reset_n = 1'b1;
    drive(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 3'b100, 16'h0, 0));
    @(posedge clk); #1;
    check("pre_mask", 32'(pending_mask), 32'h0008);
    @(negedge clk);
    drive(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 3'b011, 16'h0, 0));
    #1;
    check("pre_freeze", 32'(freeze), 32'h1);
    reset_n = 1'b0;
    #1;
    check("async_mask", 32'(pending_mask), 32'h0);
    check("async_freeze", 32'(freeze), 32'h0);
    @(negedge clk);
    set_idle();
    reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_comb", i), 32'({issue, freeze, id_exe_flush}), 32'(vecs[i].cmb));
      @(posedge clk); #1;
      check($sformatf("v%0d_mask", i), 32'(pending_mask), 32'(vecs[i].mask));
      check($sformatf("v%0d_err", i), 32'(sb_err), 32'(vecs[i].err));
    end

    // Statistics: exactly four freeze cycles after a fresh reset
    @(negedge clk);
    set_idle();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst2_err", 32'(sb_err), 32'h0);
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 3'b100, 16'h0, 0));
    @(negedge clk);
    drive(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 3'b011, 16'h0, 0));
    repeat (4) @(posedge clk);
    @(negedge clk);
    set_idle();
    #1;
`ifdef SCOREBOARD_STATS_EN
    check("stall_cycles", stall_cycles, 32'd4);
`else
    check("stall_cycles", stall_cycles, 32'd0);
`endif
    check("stats_mask", 32'(pending_mask), 32'h0008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
